// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//
// Shares the write port of a single syncfifo among N_REQ producers. Ownership is
// handed out round-robin. An owner keeps the port for at most BURST_MAX words and
// then gives it up. A full FIFO stalls the owner, and the owner keeps its turn.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   req        per-producer write request (held with stable data until granted)
//   req_dt     packed producer data, producer i in [i*DT_WIDTH +: DT_WIDTH]
//   f_full     syncfifo full flag
//   gnt        one-hot: producer's word is accepted this cycle
//   wrt_en     syncfifo write enable
//   wrt_dt     syncfifo write data
//   busy       high while a producer owns the port
//   cur_owner  current (or most recent) owner index

module fifo_wr_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DT_WIDTH  = 8,
    parameter int unsigned BURST_MAX = 4,
    localparam int unsigned OWN_W    = $clog2(N_REQ),
    localparam int unsigned CNT_W    = $clog2(BURST_MAX + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DT_WIDTH-1:0] req_dt,
    input  logic                      f_full,
    output logic [N_REQ-1:0]          gnt,
    output logic                      wrt_en,
    output logic [DT_WIDTH-1:0]       wrt_dt,
    output logic                      busy,
    output logic [OWN_W-1:0]          cur_owner
);

    typedef enum logic [0:0] {StIdle, StOwn} state_e;

    state_e             state_q, state_d;
    logic [OWN_W-1:0]   owner_q, owner_d;
    logic [OWN_W-1:0]   last_owner_q, last_owner_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;

    logic [OWN_W-1:0]    pick;
    logic [OWN_W-1:0]    cand;
    logic                pick_found;
    logic [DT_WIDTH-1:0] owner_dt;
    logic                own_write;
    logic                burst_last;

    // The owner writes only when it still requests and the FIFO has room this cycle.
    // A full FIFO therefore always blocks the write, even if a read happens in the same cycle.
    assign own_write  = (state_q == StOwn) && req[owner_q] && !f_full;
    assign burst_last = (burst_cnt_q == CNT_W'(BURST_MAX - 1));

    // Round-robin pick: the first requester found when scanning upward from last_owner+1,
    // wrapping modulo N_REQ.
    always_comb begin
        pick       = last_owner_q;
        cand       = '0;
        pick_found = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = OWN_W'((32'(last_owner_q) + k) % N_REQ);
            if (!pick_found && req[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    // Data mux for the owner's slice.
    always_comb begin
        owner_dt = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (owner_q == OWN_W'(i)) begin
                owner_dt = req_dt[i*DT_WIDTH +: DT_WIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            owner_q      <= '0;
            last_owner_q <= OWN_W'(N_REQ - 1);
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d     = StOwn;
                    owner_d     = pick;
                    burst_cnt_d = '0;
                end
            end
            StOwn: begin
                if (own_write && burst_last) begin
                    state_d      = StIdle;
                    last_owner_d = owner_q;
                    burst_cnt_d  = '0;
                end else if (!req[owner_q]) begin
                    // Owner let go. Priority still rotates past it, even if it wrote nothing.
                    state_d      = StIdle;
                    last_owner_d = owner_q;
                    burst_cnt_d  = '0;
                end else if (own_write) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
                // Otherwise the FIFO is full: hold owner and count.
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs. Because this path is purely combinational, an asynchronous reset clears
    // wrt_en and gnt at once, so a word in flight is not written.
    always_comb begin
        gnt       = '0;
        wrt_en    = 1'b0;
        wrt_dt    = '0;
        busy      = (state_q == StOwn);
        cur_owner = owner_q;
        if (own_write) begin
            gnt[owner_q] = 1'b1;
            wrt_en       = 1'b1;
            wrt_dt       = owner_dt;
        end
    end

endmodule
